touch_scan_scheduler: RTL and testbench
=======================================

TOUCH_SCAN_SCHEDULER -- requirements
Module: touch_scan_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1000: cycles PENIRQ_n must stay low before scanning starts.
REQ-002 Parameter PERIOD_CYC, default 50000: cycles from one POS_VALID to the next scan start.
REQ-003 Parameter AVG_LOG2, default 2: log2 of the number of samples averaged per axis (N = 4).
REQ-004 Parameter TMO_CYC, default 1023: maximum cycles from TRANS_REQ rise to TRANS_ACK.
REQ-005 CLK  in  1  system clock; all logic on the rising edge.
REQ-006 RST_n  in  1  reset, asynchronous, active-low.
REQ-007 PENIRQ_n  in  1  ADC pen interrupt, active-low, asynchronous to CLK.
REQ-008 TRANS_REQ  out  1  request for one ADC transaction to the transaction engine.
REQ-009 TRANS_CMD  out  8  ADC control byte for the requested transaction.
REQ-010 TRANS_ACK  in  1  one-cycle pulse from the engine: transaction complete, TRANS_DATA valid.
REQ-011 TRANS_DATA  in  12  conversion result; valid only in the TRANS_ACK cycle.
REQ-012 POS_X / POS_Y  out  12 each  averaged coordinates, held between updates.
REQ-013 POS_VALID  out  1  one-cycle pulse when POS_X/POS_Y update.
REQ-014 PEN_DOWN  out  1  high from debounce completion until pen-up is detected.
REQ-015 ERR  out  1  sticky transaction-timeout flag, cleared only by reset.

Function
REQ-016 PENIRQ_n shall pass through a 2-flop synchroniser; all uses refer to the synchronised value pen_n.
REQ-017 FSM states: IDLE, DEBOUNCE, REQ_X, WAIT_X, REQ_Y, WAIT_Y, PUBLISH, HOLDOFF.
REQ-018 IDLE -> DEBOUNCE when pen_n=0; the cycle counter clears.
REQ-019 DEBOUNCE: pen_n=1 -> IDLE; the counter reaching DEBOUNCE_CYC-1 -> REQ_X with PEN_DOWN set.
REQ-020 REQ_X/REQ_Y assert TRANS_REQ for exactly one state entry, then go to WAIT_X/WAIT_Y.
REQ-021 TRANS_REQ shall stay high throughout WAIT_* until the TRANS_ACK cycle and drop the cycle after.
REQ-022 TRANS_CMD = 8'hD0 (X) in REQ_X/WAIT_X, 8'h90 (Y) in REQ_Y/WAIT_Y, and 8'h00 elsewhere.
REQ-023 TRANS_CMD shall be stable while TRANS_REQ is high.
REQ-024 On TRANS_ACK in WAIT_X, TRANS_DATA shall be added to sum_x (width 12+AVG_LOG2, no overflow possible).
REQ-025 After WAIT_X, the state returns to REQ_X until 2^AVG_LOG2 X samples are taken, then goes to REQ_Y.
REQ-026 Y sampling uses sum_y and the same rule as X; after the last Y sample the state goes to PUBLISH.
REQ-027 PUBLISH: POS_X = sum_x >> AVG_LOG2 and POS_Y = sum_y >> AVG_LOG2, both truncated.
REQ-028 PUBLISH also pulses POS_VALID, clears sums and sample counters, then goes to HOLDOFF.
REQ-029 HOLDOFF: pen_n=1 -> IDLE; the counter reaching PERIOD_CYC-1 -> REQ_X.
REQ-030 Pen-up (pen_n=1) in REQ_*/WAIT_*: any open transaction is completed first (wait for TRANS_ACK).
REQ-031 After that pen-up completion, results are discarded, sums clear, no POS_VALID, and the state goes to IDLE.
REQ-032 PEN_DOWN shall clear on entry to IDLE.
REQ-033 TRANS_ACK outside WAIT_* shall be ignored.
REQ-034 If TRANS_ACK and pen-up coincide, the ACK closes the transaction and pen-up takes effect.
REQ-035 Timeout: if WAIT_* exceeds TMO_CYC cycles, ERR sets, TRANS_REQ drops, sums clear, and the state goes to IDLE.

Reset
REQ-036 RST_n low, asynchronously: state=IDLE, every counter, sum and synchroniser flop reset to 0.
REQ-037 RST_n low, asynchronously: outputs reset to TRANS_REQ=0, TRANS_CMD=0, POS_X=POS_Y=0, POS_VALID=0, PEN_DOWN=0, ERR=0.
REQ-038 Reset mid-transaction shall drop TRANS_REQ immediately; the engine is reset by the same RST_n.

Structure
REQ-039 A shared package shall hold: state encoding, CMD_X=8'hD0, CMD_Y=8'h90, and the ADC data width 12.
REQ-040 One sub-module, pen_debounce (synchroniser plus DEBOUNCE_CYC counter), shall output pen_n and a pen_stable strobe.
REQ-041 A single shared cycle counter shall serve the DEBOUNCE, HOLDOFF and WAIT_* timeout functions.

Verification (DEBOUNCE_CYC=8, PERIOD_CYC=32, TMO_CYC=15, AVG_LOG2=2; engine model ACKs 5 cycles after REQ)
REQ-042 PENIRQ_n low 5 cycles then high -> PEN_DOWN stays 0 and TRANS_REQ is never asserted.
REQ-043 Pen held with X data 100,101,102,104 and Y data 200,200,201,203 -> one POS_VALID pulse with POS_X=101, POS_Y=201.
REQ-044 In the REQ-043 case, the command order shall be D0,D0,D0,D0,90,90,90,90.
REQ-045 Pen held continuously -> POS_VALID spacing = 32 + 8*(1+5+1) cycles within ±2, with PEN_DOWN steady 1.
REQ-046 PENIRQ_n released during the 2nd Y transaction -> TRANS_REQ holds until ACK, then IDLE, no POS_VALID, PEN_DOWN=0.
REQ-047 Engine never ACKs -> ERR=1 at 16 cycles after REQ, TRANS_REQ=0, and ERR stays set through later scans.
REQ-048 RST_n pulsed low during WAIT_Y -> all outputs read 0 in that same cycle, and normal scanning resumes after release.

Source files
------------

// File: rtl/touch_scan_scheduler_pkg.sv
// Shared constants for the touch-screen scan scheduler: FSM state
// encoding, ADC control bytes and the ADC result width.
package touch_scan_scheduler_pkg;

    localparam int ADC_W = 12;

    localparam logic [7:0] CMD_X    = 8'hD0;
    localparam logic [7:0] CMD_Y    = 8'h90;
    localparam logic [7:0] CMD_NONE = 8'h00;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_REQ_X    = 3'd2;
    localparam logic [2:0] ST_WAIT_X   = 3'd3;
    localparam logic [2:0] ST_REQ_Y    = 3'd4;
    localparam logic [2:0] ST_WAIT_Y   = 3'd5;
    localparam logic [2:0] ST_PUBLISH  = 3'd6;
    localparam logic [2:0] ST_HOLDOFF  = 3'd7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/touch_scan_scheduler_pen_debounce.sv
// Pen interrupt synchroniser plus the scheduler's single cycle counter.
// The counter is shared with the FSM (holdoff period and transaction
// timeout); pen_stable fires on the debounce terminal count.
module pen_debounce
    import touch_scan_scheduler_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             pen_irq,
    input  logic             arm,
    input  logic             cnt_clr,
    output logic             pen_n,
    output logic             pen_stable,
    output logic [CNT_W-1:0] cnt
);

    logic pen_meta;

    // Two-flop synchroniser for the asynchronous pen interrupt
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pen_meta <= 1'b0;
            pen_n    <= 1'b0;
        end else begin
            pen_meta <= pen_irq;
            pen_n    <= pen_meta;
        end
    end

    // Shared up-counter; saturates so long dwell states cannot wrap it
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign pen_stable = arm && !pen_n && (cnt == CNT_W'(DEBOUNCE_CYC - 1));

endmodule

// File: rtl/touch_scan_scheduler.sv
// Touch-screen scan scheduler: debounces the pen interrupt, requests
// 2^AVG_LOG2 X then Y conversions, publishes the averaged position and
// repeats every PERIOD_CYC while the pen stays down.
//
// state    | meaning
// IDLE     | pen up, waiting for pen_n low
// DEBOUNCE | pen low, counting to DEBOUNCE_CYC
// REQ_X    | one cycle, launches an X transaction
// WAIT_X   | TRANS_REQ high, waiting for ACK or timeout
// REQ_Y    | one cycle, launches a Y transaction
// WAIT_Y   | TRANS_REQ high, waiting for ACK or timeout
// PUBLISH  | average sums into POS_X/POS_Y, pulse POS_VALID
// HOLDOFF  | waiting PERIOD_CYC before the next scan
module touch_scan_scheduler
    import touch_scan_scheduler_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int PERIOD_CYC   = 50000,
    parameter int AVG_LOG2     = 2,
    parameter int TMO_CYC      = 1023
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             PENIRQ_n,
    output logic             TRANS_REQ,
    output logic [7:0]       TRANS_CMD,
    input  logic             TRANS_ACK,
    input  logic [ADC_W-1:0] TRANS_DATA,
    output logic [ADC_W-1:0] POS_X,
    output logic [ADC_W-1:0] POS_Y,
    output logic             POS_VALID,
    output logic             PEN_DOWN,
    output logic             ERR
);

    localparam int CNT_W  = $clog2(max3(DEBOUNCE_CYC, PERIOD_CYC, TMO_CYC) + 1);
    localparam int SUM_W  = ADC_W + AVG_LOG2;
    localparam int SAMP_W = AVG_LOG2 + 1;
    localparam int NSAMP  = 1 << AVG_LOG2;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sum_x, sum_y;
    logic [SAMP_W-1:0] samp_cnt;
    logic [ADC_W-1:0] pos_x, pos_y;
    logic             pos_valid, pen_down, err, abort;
    logic             pen_n, pen_stable, cnt_clr;
    logic             in_wait, last_samp, tmo_hit, hold_done, leave;

    pen_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) u_pen_debounce (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .pen_irq    (PENIRQ_n),
        .arm        (state == ST_DEBOUNCE),
        .cnt_clr    (cnt_clr),
        .pen_n      (pen_n),
        .pen_stable (pen_stable),
        .cnt        (cnt)
    );

    assign in_wait   = (state == ST_WAIT_X) || (state == ST_WAIT_Y);
    assign last_samp = (samp_cnt == SAMP_W'(NSAMP - 1));
    assign tmo_hit   = (cnt == CNT_W'(TMO_CYC));
    assign hold_done = (cnt == CNT_W'(PERIOD_CYC - 1));
    // A pen-up seen earlier in the transaction still aborts at its ACK
    assign leave     = pen_n || abort;
    assign cnt_clr   = (state_nxt != state);

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (!pen_n) state_nxt = ST_DEBOUNCE;
            ST_DEBOUNCE: if (pen_n) state_nxt = ST_IDLE;
                         else if (pen_stable) state_nxt = ST_REQ_X;
            ST_REQ_X:    state_nxt = leave ? ST_IDLE : ST_WAIT_X;
            ST_WAIT_X:   if (TRANS_ACK) state_nxt = leave ? ST_IDLE : (last_samp ? ST_REQ_Y : ST_REQ_X);
                         else if (tmo_hit) state_nxt = ST_IDLE;
            ST_REQ_Y:    state_nxt = leave ? ST_IDLE : ST_WAIT_Y;
            ST_WAIT_Y:   if (TRANS_ACK) state_nxt = leave ? ST_IDLE : (last_samp ? ST_PUBLISH : ST_REQ_Y);
                         else if (tmo_hit) state_nxt = ST_IDLE;
            ST_PUBLISH:  state_nxt = ST_HOLDOFF;
            ST_HOLDOFF:  if (pen_n) state_nxt = ST_IDLE;
                         else if (hold_done) state_nxt = ST_REQ_X;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // State, accumulators and registered outputs; IDLE entry clears scan data
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= ST_IDLE;
            sum_x     <= '0;
            sum_y     <= '0;
            samp_cnt  <= '0;
            abort     <= 1'b0;
            pos_x     <= '0;
            pos_y     <= '0;
            pos_valid <= 1'b0;
            pen_down  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            pos_valid <= 1'b0;
            if (pen_stable) pen_down <= 1'b1;
            if (in_wait && pen_n) abort <= 1'b1;
            if (in_wait && TRANS_ACK) begin
                if (state == ST_WAIT_X) sum_x <= sum_x + SUM_W'(TRANS_DATA);
                else                    sum_y <= sum_y + SUM_W'(TRANS_DATA);
                samp_cnt <= last_samp ? '0 : samp_cnt + SAMP_W'(1);
            end
            if (in_wait && !TRANS_ACK && tmo_hit) err <= 1'b1;
            if (state == ST_PUBLISH) begin
                pos_x     <= sum_x[AVG_LOG2 +: ADC_W];
                pos_y     <= sum_y[AVG_LOG2 +: ADC_W];
                pos_valid <= 1'b1;
                sum_x     <= '0;
                sum_y     <= '0;
                samp_cnt  <= '0;
            end
            if (state_nxt == ST_IDLE) begin
                pen_down <= 1'b0;
                sum_x    <= '0;
                sum_y    <= '0;
                samp_cnt <= '0;
                abort    <= 1'b0;
            end
        end
    end

    // Command byte follows the state so it is stable for the whole request
    always_comb begin
        TRANS_CMD = CMD_NONE;
        if (state == ST_REQ_X || state == ST_WAIT_X) TRANS_CMD = CMD_X;
        if (state == ST_REQ_Y || state == ST_WAIT_Y) TRANS_CMD = CMD_Y;
    end

    assign TRANS_REQ = in_wait;
    assign POS_X     = pos_x;
    assign POS_Y     = pos_y;
    assign POS_VALID = pos_valid;
    assign PEN_DOWN  = pen_down;
    assign ERR       = err;

endmodule

// File: tb/tb_touch_scan_scheduler.sv
// Scoreboard bench for touch_scan_scheduler with a transaction engine
// model that ACKs 5 cycles after each TRANS_REQ rise.
module tb_touch_scan_scheduler;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        PENIRQ_n;
    logic        TRANS_REQ;
    logic [7:0]  TRANS_CMD;
    logic        TRANS_ACK;
    logic [11:0] TRANS_DATA;
    logic [11:0] POS_X, POS_Y;
    logic        POS_VALID, PEN_DOWN, ERR;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int ack_cnt = 0;
    int pos_cnt = 0;
    int pd_hi_cnt = 0;
    bit eng_on = 1'b1;
    bit req_prev = 1'b0;
    int cmd_q[$];
    int data_q[$];
    int posx_q[$];
    int posy_q[$];
    int pos_cyc_q[$];

    touch_scan_scheduler #(
        .DEBOUNCE_CYC (8),
        .PERIOD_CYC   (32),
        .AVG_LOG2     (2),
        .TMO_CYC      (15)
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .PENIRQ_n   (PENIRQ_n),
        .TRANS_REQ  (TRANS_REQ),
        .TRANS_CMD  (TRANS_CMD),
        .TRANS_ACK  (TRANS_ACK),
        .TRANS_DATA (TRANS_DATA),
        .POS_X      (POS_X),
        .POS_Y      (POS_Y),
        .POS_VALID  (POS_VALID),
        .PEN_DOWN   (PEN_DOWN),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_req"},   TRANS_REQ, 0);
        chk({tag, "_cmd"},   TRANS_CMD, 0);
        chk({tag, "_posx"},  POS_X, 0);
        chk({tag, "_posy"},  POS_Y, 0);
        chk({tag, "_valid"}, POS_VALID, 0);
        chk({tag, "_pd"},    PEN_DOWN, 0);
        chk({tag, "_err"},   ERR, 0);
    endtask

    task automatic push_scan(input int x0, input int x1, input int x2, input int x3,
                             input int y0, input int y1, input int y2, input int y3);
        for (int i = 0; i < 4; i++) cmd_q.push_back(8'hD0);
        for (int i = 0; i < 4; i++) cmd_q.push_back(8'h90);
        data_q.push_back(x0); data_q.push_back(x1); data_q.push_back(x2); data_q.push_back(x3);
        data_q.push_back(y0); data_q.push_back(y1); data_q.push_back(y2); data_q.push_back(y3);
        posx_q.push_back((x0 + x1 + x2 + x3) / 4);
        posy_q.push_back((y0 + y1 + y2 + y3) / 4);
    endtask

    task automatic wait_rises(input int n);
        int b = 0;
        while (rise_cnt < n && b < 2000) begin @(negedge CLK); b++; end
        if (rise_cnt < n) chk("wait_rise", rise_cnt, n);
    endtask

    task automatic wait_acks(input int n);
        int b = 0;
        while (ack_cnt < n && b < 2000) begin @(negedge CLK); b++; end
        if (ack_cnt < n) chk("wait_ack", ack_cnt, n);
    endtask

    task automatic wait_pos(input int n);
        int b = 0;
        while (pos_cnt < n && b < 2000) begin @(negedge CLK); b++; end
        if (pos_cnt < n) chk("wait_pos", pos_cnt, n);
    endtask

    // Transaction engine: sees a REQ rise, checks the command, ACKs 5 cycles later
    initial begin
        bit ok;
        TRANS_ACK  = 1'b0;
        TRANS_DATA = '0;
        forever begin
            @(negedge CLK);
            if (TRANS_REQ && !req_prev) begin
                rise_cnt++;
                if (eng_on) begin
                    if (cmd_q.size() > 0) chk("cmd", TRANS_CMD, cmd_q.pop_front());
                    ok = 1'b1;
                    for (int k = 0; k < 5; k++) begin
                        @(negedge CLK);
                        if (!TRANS_REQ) begin ok = 1'b0; break; end
                    end
                    if (ok) begin
                        TRANS_ACK  = 1'b1;
                        TRANS_DATA = (data_q.size() > 0) ? 12'(data_q.pop_front()) : 12'd0;
                        ack_cnt++;
                        @(negedge CLK);
                        TRANS_ACK  = 1'b0;
                    end
                end
            end
            req_prev = TRANS_REQ;
        end
    end

    // Output monitor: scoreboard pop on each POS_VALID pulse
    initial begin
        forever begin
            @(negedge CLK);
            if (PEN_DOWN) pd_hi_cnt++;
            if (POS_VALID) begin
                pos_cnt++;
                pos_cyc_q.push_back(cyc);
                if (posx_q.size() > 0) begin
                    chk("pos_x", POS_X, posx_q.pop_front());
                    chk("pos_y", POS_Y, posy_q.pop_front());
                    chk("pd_at_pos", PEN_DOWN, 1);
                end else begin
                    chk("pos_unexp", POS_VALID, 0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int base, abase, pbase, sp;
        RST_n    = 1'b0;
        PENIRQ_n = 1'b1;
        repeat (3) @(negedge CLK);
        chk_outs_zero("rst");
        RST_n = 1'b1;
        repeat (5) @(negedge CLK);

        // Short pen glitch must not start a scan
        PENIRQ_n = 1'b0;
        repeat (5) @(negedge CLK);
        PENIRQ_n = 1'b1;
        repeat (30) @(negedge CLK);
        chk("glitch_pd", pd_hi_cnt, 0);
        chk("glitch_req", rise_cnt, 0);

        // Continuous pen: two scans, averaging and period
        push_scan(100, 101, 102, 104, 200, 200, 201, 203);
        push_scan(4095, 4095, 4095, 4094, 0, 1, 2, 3);
        PENIRQ_n = 1'b0;
        wait_pos(2);
        PENIRQ_n = 1'b1;
        sp = (pos_cyc_q.size() >= 2) ? pos_cyc_q[1] - pos_cyc_q[0] : 0;
        chk("period_in_86_90", int'(sp >= 86 && sp <= 90), 1);
        repeat (10) @(negedge CLK);
        chk("pd_after_up", PEN_DOWN, 0);
        chk("rises_two_scans", rise_cnt, 16);
        chk("cmd_q_drained", cmd_q.size(), 0);

        // Pen-up during the second Y transaction
        base  = rise_cnt;
        abase = ack_cnt;
        pbase = pos_cnt;
        for (int i = 0; i < 4; i++) cmd_q.push_back(8'hD0);
        for (int i = 0; i < 2; i++) cmd_q.push_back(8'h90);
        for (int i = 1; i <= 6; i++) data_q.push_back(i * 10);
        PENIRQ_n = 1'b0;
        wait_rises(base + 6);
        PENIRQ_n = 1'b1;
        repeat (3) @(negedge CLK);
        chk("up_hold_req", TRANS_REQ, 1);
        chk("up_hold_cmd", TRANS_CMD, 8'h90);
        wait_acks(abase + 6);
        repeat (2) @(negedge CLK);
        chk("up_req", TRANS_REQ, 0);
        chk("up_cmd", TRANS_CMD, 0);
        chk("up_pd", PEN_DOWN, 0);
        repeat (60) @(negedge CLK);
        chk("up_no_rise", rise_cnt, base + 6);
        chk("up_no_pos", pos_cnt, pbase);

        // Timeout: engine silent, ERR at 16 cycles after the REQ rise
        eng_on   = 1'b0;
        PENIRQ_n = 1'b0;
        begin
            int b = 0;
            while (!TRANS_REQ && b < 200) begin @(negedge CLK); b++; end
            if (!TRANS_REQ) chk("tmo_wait_req", TRANS_REQ, 1);
        end
        repeat (15) @(negedge CLK);
        chk("tmo_pre_err", ERR, 0);
        chk("tmo_pre_req", TRANS_REQ, 1);
        @(negedge CLK);
        chk("tmo_err", ERR, 1);
        chk("tmo_req", TRANS_REQ, 0);
        pbase = pos_cnt;
        push_scan(1, 2, 3, 4, 4000, 4001, 4002, 4003);
        eng_on = 1'b1;
        wait_pos(pbase + 1);
        chk("err_sticky", ERR, 1);
        PENIRQ_n = 1'b1;
        repeat (10) @(negedge CLK);

        // Reset asserted during WAIT_Y, then a clean scan
        base = rise_cnt;
        for (int i = 0; i < 4; i++) cmd_q.push_back(8'hD0);
        cmd_q.push_back(8'h90);
        for (int i = 0; i < 4; i++) data_q.push_back(7);
        PENIRQ_n = 1'b0;
        wait_rises(base + 5);
        repeat (2) @(negedge CLK);
        chk("rst_pre_req", TRANS_REQ, 1);
        RST_n = 1'b0;
        #1;
        chk_outs_zero("rst_mid");
        @(negedge CLK);
        data_q.delete();
        cmd_q.delete();
        RST_n = 1'b1;
        pbase = pos_cnt;
        push_scan(300, 300, 300, 300, 500, 501, 502, 503);
        wait_pos(pbase + 1);
        chk("post_rst_err", ERR, 0);
        chk("post_rst_cmd_q", cmd_q.size(), 0);
        PENIRQ_n = 1'b1;
        repeat (10) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
